// File: rtl/mem_req_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_sequencer
// Description : Round-robin read sequencer in front of memory_out_demux. It
//               reads a synchronous RAM, presents a tagged word, and completes
//               a four-phase handshake on ack_to_mem.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_req_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 14,
    parameter int RAM_LAT     = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                instr_req,
    input  logic [ADDR_W-1:0]   instr_addr,
    output logic                instr_done,
    input  logic                cache_req,
    input  logic [ADDR_W-1:0]   cache_addr,
    output logic                cache_done,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic                ram_rd_en,
    input  logic [DATA_W-1:0]   ram_rdata,
    output logic [DATA_W+1:0]   memory_out,
    output logic [1:0]          PH0,
    output logic [1:0]          PH1,
    input  logic                ack_to_mem,
    output logic                busy
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_READ    = 3'd1;
    localparam logic [2:0] c_ST_PRESENT = 3'd2;
    localparam logic [2:0] c_ST_RELEASE = 3'd3;
    localparam logic [2:0] c_ST_DONE    = 3'd4;

    localparam logic [1:0] c_PH_SEL  = 2'b10;
    localparam logic [1:0] c_PH_IDLE = 2'b01;
    localparam logic [2:0] c_LAT     = 3'(RAM_LAT);

    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic [2:0]             r_state;
    logic [2:0]             r_lat_cnt;
    logic                   r_grant_cache;
    logic                   r_last_cache;
    logic                   r_ack_low;
    logic                   w_ack_s;
    logic                   w_pick_cache;

    assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

    // Reset value of r_last_cache makes instr win the first contention.
    assign w_pick_cache = cache_req & (~instr_req | ~r_last_cache);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack_to_mem};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_ST_IDLE;
            r_lat_cnt     <= '0;
            r_grant_cache <= 1'b0;
            r_last_cache  <= 1'b1;
            r_ack_low     <= 1'b0;
            ram_addr      <= '0;
            ram_rd_en     <= 1'b0;
            memory_out    <= '0;
            PH0           <= c_PH_IDLE;
            PH1           <= c_PH_IDLE;
            instr_done    <= 1'b0;
            cache_done    <= 1'b0;
            busy          <= 1'b0;
        end else begin
            ram_rd_en  <= 1'b0;
            instr_done <= 1'b0;
            cache_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (instr_req || cache_req) begin
                        r_grant_cache <= w_pick_cache;
                        ram_addr      <= w_pick_cache ? cache_addr : instr_addr;
                        ram_rd_en     <= 1'b1;
                        r_lat_cnt     <= '0;
                        busy          <= 1'b1;
                        r_state       <= c_ST_READ;
                    end
                end
                c_ST_READ: begin
                    if (r_lat_cnt == c_LAT) begin
                        memory_out <= {2'b10, ram_rdata};
                        if (r_grant_cache) begin
                            PH1 <= c_PH_SEL;
                        end else begin
                            PH0 <= c_PH_SEL;
                        end
                        r_ack_low <= 1'b0;
                        r_state   <= c_ST_PRESENT;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 3'd1;
                    end
                end
                c_ST_PRESENT: begin
                    // A stale high ack must be seen low once before it counts.
                    if (!w_ack_s) begin
                        r_ack_low <= 1'b1;
                    end else if (r_ack_low) begin
                        memory_out <= '0;
                        PH0        <= c_PH_IDLE;
                        PH1        <= c_PH_IDLE;
                        r_state    <= c_ST_RELEASE;
                    end
                end
                c_ST_RELEASE: begin
                    if (!w_ack_s) begin
                        instr_done <= ~r_grant_cache;
                        cache_done <= r_grant_cache;
                        r_state    <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    r_last_cache <= r_grant_cache;
                    busy         <= 1'b0;
                    r_state      <= c_ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_req_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_req_sequencer
// Description : Self-checking bench for mem_req_sequencer (RAM_LAT 1 and 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_req_sequencer;

    localparam logic [13:0] c_GARB = 14'h2AAA;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        instr_req = 1'b0, cache_req = 1'b0, ack_to_mem = 1'b0;
    logic [7:0]  instr_addr = '0, cache_addr = '0;
    logic        instr_done, cache_done, ram_rd_en, busy;
    logic [7:0]  ram_addr;
    logic [13:0] ram_rdata;
    logic [15:0] memory_out;
    logic [1:0]  PH0, PH1;

    logic        instr_req3 = 1'b0, cache_req3 = 1'b0, ack3 = 1'b0;
    logic [7:0]  instr_addr3 = '0, cache_addr3 = '0;
    logic        instr_done3, cache_done3, ram_rd_en3, busy3;
    logic [7:0]  ram_addr3;
    logic [13:0] ram_rdata3;
    logic [15:0] memory_out3;
    logic [1:0]  PH0_3, PH1_3;

    logic [13:0] mem [0:255];
    logic [13:0] r_p1;
    logic [13:0] r_p3 [0:2];

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        ireq, creq, ack;
        logic [15:0] mo;
        logic [1:0]  ph0, ph1;
        logic        rd, idone, cdone, busy;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    mem_req_sequencer #(.ADDR_W(8), .DATA_W(14), .RAM_LAT(1), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_req(instr_req), .instr_addr(instr_addr), .instr_done(instr_done),
        .cache_req(cache_req), .cache_addr(cache_addr), .cache_done(cache_done),
        .ram_addr(ram_addr), .ram_rd_en(ram_rd_en), .ram_rdata(ram_rdata),
        .memory_out(memory_out), .PH0(PH0), .PH1(PH1),
        .ack_to_mem(ack_to_mem), .busy(busy)
    );

    mem_req_sequencer #(.ADDR_W(8), .DATA_W(14), .RAM_LAT(3), .SYNC_STAGES(2)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .instr_req(instr_req3), .instr_addr(instr_addr3), .instr_done(instr_done3),
        .cache_req(cache_req3), .cache_addr(cache_addr3), .cache_done(cache_done3),
        .ram_addr(ram_addr3), .ram_rd_en(ram_rd_en3), .ram_rdata(ram_rdata3),
        .memory_out(memory_out3), .PH0(PH0_3), .PH1(PH1_3),
        .ack_to_mem(ack3), .busy(busy3)
    );

    // RAM models drive a junk pattern whenever the read data is not valid.
    always @(posedge clk) begin
        r_p1    <= ram_rd_en ? mem[ram_addr] : c_GARB;
        r_p3[0] <= ram_rd_en3 ? mem[ram_addr3] : c_GARB;
        r_p3[1] <= r_p3[0];
        r_p3[2] <= r_p3[1];
    end
    assign ram_rdata  = r_p1;
    assign ram_rdata3 = r_p3[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Cycle table for one isolated transfer; c selects the cache requester.
    task automatic build(input logic c, input logic [15:0] w);
        logic [5:0] rows [13];
        vec_t v;
        // {req, ack, presented, strobe, done, busy}
        rows = '{6'b100101, 6'b100001, 6'b101001, 6'b101001, 6'b101001,
                 6'b111001, 6'b111001, 6'b110001, 6'b100001, 6'b100001,
                 6'b100011, 6'b000000, 6'b000000};
        vecs.delete();
        foreach (rows[i]) begin
            v.ireq  = rows[i][5] & ~c;
            v.creq  = rows[i][5] & c;
            v.ack   = rows[i][4];
            v.mo    = rows[i][3] ? w : 16'h0000;
            v.ph0   = (rows[i][3] & ~c) ? 2'b10 : 2'b01;
            v.ph1   = (rows[i][3] & c) ? 2'b10 : 2'b01;
            v.rd    = rows[i][2];
            v.idone = rows[i][1] & ~c;
            v.cdone = rows[i][1] & c;
            v.busy  = rows[i][0];
            vecs.push_back(v);
        end
    endtask

    task automatic run_table(input string name, input logic [7:0] exp_addr);
        foreach (vecs[i]) begin
            instr_req  = vecs[i].ireq;
            cache_req  = vecs[i].creq;
            ack_to_mem = vecs[i].ack;
            @(negedge clk);
            check($sformatf("%s[%0d]", name, i),
                  {memory_out, PH0, PH1, ram_rd_en, instr_done, cache_done, busy},
                  {vecs[i].mo, vecs[i].ph0, vecs[i].ph1, vecs[i].rd,
                   vecs[i].idone, vecs[i].cdone, vecs[i].busy});
            if (vecs[i].rd) check($sformatf("%s[%0d]/addr", name, i), ram_addr, exp_addr);
        end
    endtask

    task automatic do_transfer(input string name, input logic is_cache, input logic [7:0] exp_addr,
                               input logic [15:0] exp_word, input logic stale);
        bit ok;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ram_rd_en) begin ok = 1; break; end
        end
        if (!ok) begin timeout({name, "/strobe"}); return; end
        check({name, "/addr"}, ram_addr, exp_addr);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (memory_out[15:14] == 2'b10) begin ok = 1; break; end
        end
        if (!ok) begin timeout({name, "/present"}); return; end
        check({name, "/word"}, {memory_out, PH0, PH1},
              {exp_word, is_cache ? 2'b01 : 2'b10, is_cache ? 2'b10 : 2'b01});
        if (stale) begin
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                check({name, "/stale_hold"}, memory_out, exp_word);
            end
            ack_to_mem = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                check({name, "/low_hold"}, memory_out, exp_word);
            end
        end
        ack_to_mem = 1'b1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (memory_out == 16'h0000) begin ok = 1; break; end
        end
        if (!ok) begin timeout({name, "/release"}); return; end
        check({name, "/release"}, {PH0, PH1, busy, instr_done, cache_done}, {2'b01, 2'b01, 3'b100});
        ack_to_mem = 1'b0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (instr_done || cache_done) begin ok = 1; break; end
        end
        if (!ok) begin timeout({name, "/done"}); return; end
        check({name, "/done"}, {instr_done, cache_done}, {~is_cache, is_cache});
        @(negedge clk);
        check({name, "/done_pulse"}, {instr_done, cache_done}, 2'b00);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit ok;
        int lat;
        mem[8'h05] = 14'h1ABC;
        mem[8'h7F] = 14'h0001;
        mem[8'h22] = 14'h2C3D;

        repeat (3) @(negedge clk);
        check("reset_state",
              {memory_out, PH0, PH1, ram_rd_en, ram_addr, instr_done, cache_done, busy},
              {16'h0000, 2'b01, 2'b01, 1'b0, 8'h00, 3'b000});
        check("reset_state3", {memory_out3, PH0_3, PH1_3, busy3}, {16'h0000, 2'b01, 2'b01, 1'b0});
        rst_n = 1'b1;

        instr_addr = 8'h05;
        build(1'b0, 16'h9ABC);
        run_table("instr", 8'h05);
        cache_addr = 8'h7F;
        build(1'b1, 16'h8001);
        run_table("cache", 8'h7F);

        reset_pulse();
        instr_req = 1'b1;
        cache_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            do_transfer($sformatf("contend%0d", k), k[0], k[0] ? 8'h7F : 8'h05,
                        k[0] ? 16'h8001 : 16'h9ABC, 1'b0);
        end
        instr_req = 1'b0;
        cache_req = 1'b0;

        ack_to_mem = 1'b1;
        repeat (3) @(negedge clk);
        instr_req = 1'b1;
        do_transfer("stale", 1'b0, 8'h05, 16'h9ABC, 1'b1);
        instr_req = 1'b0;

        repeat (2) @(negedge clk);
        instr_req = 1'b1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (memory_out[15:14] == 2'b10) begin ok = 1; break; end
        end
        if (!ok) timeout("midreset/present");
        rst_n = 1'b0;
        #1;
        check("midreset/outputs", {memory_out, PH0, PH1, busy}, {16'h0000, 2'b01, 2'b01, 1'b0});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midreset/no_done", {instr_done, cache_done, busy}, 3'b000);
        end
        rst_n = 1'b1;
        do_transfer("rerun", 1'b0, 8'h05, 16'h9ABC, 1'b0);
        instr_req = 1'b0;

        instr_addr3 = 8'h22;
        instr_req3  = 1'b1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ram_rd_en3) begin ok = 1; break; end
        end
        if (!ok) timeout("lat3/strobe");
        check("lat3/addr", ram_addr3, 8'h22);
        ok  = 0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (memory_out3[15:14] == 2'b10) begin ok = 1; break; end
        end
        if (!ok) timeout("lat3/present");
        check("lat3/latency", lat, 4);
        check("lat3/word", {memory_out3, PH0_3, PH1_3}, {16'hAC3D, 2'b10, 2'b01});
        ack3 = 1'b1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (memory_out3 == 16'h0000) begin ok = 1; break; end
        end
        if (!ok) timeout("lat3/release");
        ack3 = 1'b0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (instr_done3) begin ok = 1; break; end
        end
        if (!ok) timeout("lat3/done");
        check("lat3/done", {instr_done3, cache_done3}, 2'b10);
        instr_req3 = 1'b0;

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
